// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and the load/store buffer.
// Optional macro IO_STALL_EN holds store beats to I/O space while the UART buffer is full.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_start,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_stop,
  output logic              if_finish,
  output logic [31:0]       if_inst,
  input  logic              ls_start,
  input  logic              ls_wr,
  input  logic [2:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic              ls_rollback,
  output logic              ls_finish,
  output logic [31:0]       ls_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;

  logic                if_pend_q, if_pend_d;
  logic [ADDR_W-1:0]   if_addr_q, if_addr_d;
  logic                ls_pend_q, ls_pend_d;
  logic                ls_wr_q, ls_wr_d;
  logic [2:0]          ls_size_q, ls_size_d;
  logic [ADDR_W-1:0]   ls_addr_q, ls_addr_d;
  logic [31:0]         ls_wdata_q, ls_wdata_d;

  logic                if_finish_q, if_finish_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic                ls_finish_q, ls_finish_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;

  logic                io_stall;
  logic                last_beat;
  logic [2:0]          cnt_inc;
  logic [ADDR_W-1:0]   next_a;
  logic [31:0]         beat_data;
  logic                if_go, ls_go;

`ifdef IO_STALL_EN
  assign io_stall = (state_q == LS_WR) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic io_full_unused;
  assign io_full_unused = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  assign cnt_inc   = cnt_q + 3'd1;
  assign next_a    = base_q + {{(ADDR_W-3){1'b0}}, cnt_inc};
  assign last_beat = (cnt_q == size_q - 3'd1);
  // An abort sampled on the launch edge must also cancel the launch.
  assign ls_go     = ls_pend_q && !(ls_rollback && !ls_wr_q);
  assign if_go     = if_pend_q && !if_stop;

  always_comb begin
    beat_data = data_q;
    case (cnt_q[1:0])
      2'd0:    beat_data[7:0]   = mem_din;
      2'd1:    beat_data[15:8]  = mem_din;
      2'd2:    beat_data[23:16] = mem_din;
      default: beat_data[31:24] = mem_din;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    if_pend_d   = if_pend_q;
    if_addr_d   = if_addr_q;
    ls_pend_d   = ls_pend_q;
    ls_wr_d     = ls_wr_q;
    ls_size_d   = ls_size_q;
    ls_addr_d   = ls_addr_q;
    ls_wdata_d  = ls_wdata_q;
    if_finish_d = 1'b0;
    if_inst_d   = if_inst_q;
    ls_finish_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (ls_go) begin
          state_d   = ls_wr_q ? LS_WR : LS_RD;
          base_d    = ls_addr_q;
          size_d    = ls_size_q;
          wdata_d   = ls_wdata_q;
          mem_a_d   = ls_addr_q;
          cnt_d     = 3'd0;
          data_d    = 32'd0;
          ls_pend_d = 1'b0;
          if (ls_wr_q) mem_dout_d = ls_wdata_q[7:0];
        end else if (if_go) begin
          state_d   = IF_RD;
          base_d    = if_addr_q;
          size_d    = 3'd4;
          mem_a_d   = if_addr_q;
          cnt_d     = 3'd0;
          data_d    = 32'd0;
          if_pend_d = 1'b0;
        end
      end
      IF_RD: begin
        if (if_stop) begin
          state_d = IDLE;
        end else begin
          data_d = beat_data;
          if (last_beat) begin
            if_finish_d = 1'b1;
            if_inst_d   = beat_data;
            state_d     = IDLE;
          end else begin
            cnt_d   = cnt_inc;
            mem_a_d = next_a;
          end
        end
      end
      LS_RD: begin
        if (ls_rollback) begin
          state_d = IDLE;
        end else begin
          data_d = beat_data;
          if (last_beat) begin
            ls_finish_d = 1'b1;
            ls_rdata_d  = beat_data;
            state_d     = IDLE;
          end else begin
            cnt_d   = cnt_inc;
            mem_a_d = next_a;
          end
        end
      end
      LS_WR: begin
        // Stores are committed: rollback is ignored here.
        if (!io_stall) begin
          if (last_beat) begin
            ls_finish_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = next_a;
            mem_dout_d = byte_sel(wdata_q, cnt_inc[1:0]);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New requests land after launch so a start on the launch edge stays pending.
    if (if_start) begin
      if_pend_d = 1'b1;
      if_addr_d = if_addr;
    end
    if (if_stop) if_pend_d = 1'b0;
    if (ls_start) begin
      ls_pend_d  = 1'b1;
      ls_wr_d    = ls_wr;
      ls_size_d  = ls_size;
      ls_addr_d  = ls_addr;
      ls_wdata_d = ls_wdata;
    end
    if (ls_rollback && !ls_wr_d) ls_pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      size_q      <= 3'd0;
      wdata_q     <= 32'd0;
      data_q      <= 32'd0;
      mem_a_q     <= '0;
      mem_dout_q  <= 8'd0;
      if_pend_q   <= 1'b0;
      if_addr_q   <= '0;
      ls_pend_q   <= 1'b0;
      ls_wr_q     <= 1'b0;
      ls_size_q   <= 3'd0;
      ls_addr_q   <= '0;
      ls_wdata_q  <= 32'd0;
      if_finish_q <= 1'b0;
      if_inst_q   <= 32'd0;
      ls_finish_q <= 1'b0;
      ls_rdata_q  <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      if_pend_q   <= if_pend_d;
      if_addr_q   <= if_addr_d;
      ls_pend_q   <= ls_pend_d;
      ls_wr_q     <= ls_wr_d;
      ls_size_q   <= ls_size_d;
      ls_addr_q   <= ls_addr_d;
      ls_wdata_q  <= ls_wdata_d;
      if_finish_q <= if_finish_d;
      if_inst_q   <= if_inst_d;
      ls_finish_q <= ls_finish_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  // RAM stalls with rdy, so a write must not land during a freeze.
  assign mem_wr    = (state_q == LS_WR) && rdy && !io_stall;
  assign if_finish = if_finish_q;
  assign if_inst   = if_inst_q;
  assign ls_finish = ls_finish_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus corner-case sequences.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_start, if_stop, if_finish;
  logic [31:0] if_addr, if_inst;
  logic        ls_start, ls_wr, ls_rollback, ls_finish;
  logic [2:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_start(if_start), .if_addr(if_addr), .if_stop(if_stop),
    .if_finish(if_finish), .if_inst(if_inst),
    .ls_start(ls_start), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rollback(ls_rollback),
    .ls_finish(ls_finish), .ls_rdata(ls_rdata),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM contents: a few fixed words, elsewhere the low address byte xor 0xC3.
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: rom = 8'h13;
      32'h101: rom = 8'h05;
      32'h102: rom = 8'h00;
      32'h103: rom = 8'h00;
      32'h000: rom = 8'h93;
      32'h001: rom = 8'h00;
      32'h002: rom = 8'h10;
      32'h003: rom = 8'h00;
      32'h200: rom = 8'hAA;
      32'h201: rom = 8'h55;
      default: rom = a[7:0] ^ 8'hC3;
    endcase
  endfunction

  assign mem_din = rom(mem_a);

  typedef struct {
    logic        is_ls;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s;
    logic [31:0] sh;
    s = v.is_ls ? int'(v.size) : 4;
    if (v.is_ls) begin
      ls_start = 1'b1; ls_wr = v.wr; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_start = 1'b1; if_addr = v.addr;
    end
    tick();
    if_start = 1'b0; ls_start = 1'b0;
    for (int k = 0; k < s; k++) begin
      tick();
      chk($sformatf("v%0d mem_a beat%0d", idx, k), mem_a, v.addr + 32'(k));
      chk($sformatf("v%0d mem_wr beat%0d", idx, k), mem_wr, v.wr);
      if (v.wr) begin
        sh = v.exp >> (8 * k);
        chk($sformatf("v%0d mem_dout beat%0d", idx, k), mem_dout, sh[7:0]);
      end
      chk($sformatf("v%0d early finish beat%0d", idx, k), v.is_ls ? ls_finish : if_finish, 1'b0);
    end
    tick();
    chk($sformatf("v%0d finish", idx), v.is_ls ? ls_finish : if_finish, 1'b1);
    if (!v.wr) chk($sformatf("v%0d data", idx), v.is_ls ? ls_rdata : if_inst, v.exp);
    chk($sformatf("v%0d mem_wr after", idx), mem_wr, 1'b0);
    tick();
    chk($sformatf("v%0d finish pulse width", idx), v.is_ls ? ls_finish : if_finish, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'd4, 32'h100,   32'h0,        32'h00000513};
    vecs[1] = '{1'b1, 1'b0, 3'd4, 32'h40,    32'h0,        32'h80818283};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 32'h200,   32'h0,        32'h000055AA};
    vecs[3] = '{1'b1, 1'b0, 3'd1, 32'h37,    32'h0,        32'h000000F4};
    vecs[4] = '{1'b1, 1'b1, 3'd4, 32'h80,    32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b1, 3'd2, 32'h90,    32'h12345678, 32'h00005678};
    vecs[6] = '{1'b1, 1'b1, 3'd1, 32'h30000, 32'h000000A5, 32'h000000A5};
    vecs[7] = '{1'b0, 1'b0, 3'd4, 32'h0,     32'h0,        32'h00100093};

    rst = 1'b1; rdy = 1'b1;
    if_start = 1'b0; if_addr = 32'h0; if_stop = 1'b0;
    ls_start = 1'b0; ls_wr = 1'b0; ls_size = 3'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
    ls_rollback = 1'b0; io_buffer_full = 1'b0;
    tick(); tick();
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_dout", mem_dout, 8'h0);
    chk("reset mem_wr", mem_wr, 1'b0);
    chk("reset if_finish", if_finish, 1'b0);
    chk("reset ls_finish", ls_finish, 1'b0);
    chk("reset if_inst", if_inst, 32'h0);
    chk("reset ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous requests: LSB wins, fetch follows with no idle beat.
    if_start = 1'b1; if_addr = 32'h0;
    ls_start = 1'b1; ls_wr = 1'b0; ls_size = 3'd2; ls_addr = 32'h200;
    tick();
    if_start = 1'b0; ls_start = 1'b0;
    tick(); chk("simul ls beat0 addr", mem_a, 32'h200);
    tick(); chk("simul ls beat1 addr", mem_a, 32'h201);
    tick();
    chk("simul ls_finish", ls_finish, 1'b1);
    chk("simul ls_rdata", ls_rdata, 32'h000055AA);
    chk("simul if not done", if_finish, 1'b0);
    tick(); chk("simul if beat0 addr", mem_a, 32'h0);
    tick(); tick(); tick();
    chk("simul if beat3 addr", mem_a, 32'h3);
    chk("simul if early", if_finish, 1'b0);
    tick();
    chk("simul if_finish", if_finish, 1'b1);
    chk("simul if_inst", if_inst, 32'h00100093);
    tick();

    // Fetch aborted in its third beat; a store queued behind it then runs.
    if_start = 1'b1; if_addr = 32'h100;
    tick(); if_start = 1'b0;
    tick();
    ls_start = 1'b1; ls_wr = 1'b1; ls_size = 3'd4; ls_addr = 32'h80; ls_wdata = 32'h11223344;
    tick(); ls_start = 1'b0;
    tick();
    chk("abort third beat addr", mem_a, 32'h102);
    if_stop = 1'b1;
    tick(); if_stop = 1'b0;
    chk("abort no if_finish", if_finish, 1'b0);
    chk("abort idle mem_wr", mem_wr, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sh;
      tick();
      sh = 32'h11223344 >> (8 * k);
      chk($sformatf("abort store wr beat%0d", k), mem_wr, 1'b1);
      chk($sformatf("abort store addr beat%0d", k), mem_a, 32'h80 + 32'(k));
      chk($sformatf("abort store dout beat%0d", k), mem_dout, sh[7:0]);
      chk($sformatf("abort no if_finish beat%0d", k), if_finish, 1'b0);
    end
    tick();
    chk("abort store finish", ls_finish, 1'b1);
    chk("abort store wr off", mem_wr, 1'b0);
    tick();

    // Rollback during a word load suppresses the finish.
    ls_start = 1'b1; ls_wr = 1'b0; ls_size = 3'd4; ls_addr = 32'h40;
    tick(); ls_start = 1'b0;
    tick(); tick();
    chk("rollback load addr", mem_a, 32'h41);
    ls_rollback = 1'b1;
    tick(); ls_rollback = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rollback load no finish %0d", k), ls_finish, 1'b0);
      tick();
    end

    // Rollback during a byte store is ignored.
    ls_start = 1'b1; ls_wr = 1'b1; ls_size = 3'd1; ls_addr = 32'h30000; ls_wdata = 32'h0000005C;
    tick(); ls_start = 1'b0; ls_rollback = 1'b1;
    tick();
    chk("rollback store wr", mem_wr, 1'b1);
    chk("rollback store addr", mem_a, 32'h30000);
    chk("rollback store dout", mem_dout, 8'h5C);
    tick(); ls_rollback = 1'b0;
    chk("rollback store finish", ls_finish, 1'b1);
    tick();

    // I/O buffer full for three cycles on a store to I/O space.
    ls_start = 1'b1; ls_wr = 1'b1; ls_size = 3'd1; ls_addr = 32'h30000; ls_wdata = 32'h0000003C;
    tick(); ls_start = 1'b0; io_buffer_full = 1'b1;
`ifdef IO_STALL_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("io stall wr off %0d", k), mem_wr, 1'b0);
      chk($sformatf("io stall no finish %0d", k), ls_finish, 1'b0);
    end
    tick(); io_buffer_full = 1'b0; #1;
    chk("io stall wr issue", mem_wr, 1'b1);
    chk("io stall dout", mem_dout, 8'h3C);
    tick();
    chk("io stall finish", ls_finish, 1'b1);
`else
    tick();
    chk("io nostall wr", mem_wr, 1'b1);
    chk("io nostall dout", mem_dout, 8'h3C);
    tick();
    chk("io nostall finish", ls_finish, 1'b1);
    io_buffer_full = 1'b0;
`endif
    tick();

    // rdy low for two cycles mid-fetch.
    if_start = 1'b1; if_addr = 32'h100;
    tick(); if_start = 1'b0;
    tick(); tick();
    chk("freeze pre addr", mem_a, 32'h101);
    rdy = 1'b0;
    tick(); chk("freeze hold addr 1", mem_a, 32'h101);
    tick(); chk("freeze hold addr 2", mem_a, 32'h101);
    chk("freeze no finish", if_finish, 1'b0);
    rdy = 1'b1;
    tick(); chk("freeze resume addr", mem_a, 32'h102);
    tick(); chk("freeze beat3 addr", mem_a, 32'h103);
    chk("freeze early finish", if_finish, 1'b0);
    tick();
    chk("freeze if_finish", if_finish, 1'b1);
    chk("freeze if_inst", if_inst, 32'h00000513);
    tick();

    // rdy low masks mem_wr combinationally.
    ls_start = 1'b1; ls_wr = 1'b1; ls_size = 3'd1; ls_addr = 32'h90; ls_wdata = 32'h00000077;
    tick(); ls_start = 1'b0;
    tick();
    chk("rdy mask wr on", mem_wr, 1'b1);
    rdy = 1'b0; #1;
    chk("rdy mask wr off", mem_wr, 1'b0);
    rdy = 1'b1; #1;
    tick();
    chk("rdy mask finish", ls_finish, 1'b1);
    tick();

    // Async reset in the middle of a store, with a fetch pending behind it.
    ls_start = 1'b1; ls_wr = 1'b1; ls_size = 3'd4; ls_addr = 32'h80; ls_wdata = 32'hCAFEF00D;
    tick(); ls_start = 1'b0;
    if_start = 1'b1; if_addr = 32'h100;
    tick(); if_start = 1'b0;
    tick();
    chk("pre-reset wr", mem_wr, 1'b1);
    #2 rst = 1'b1; #1;
    chk("async reset mem_wr", mem_wr, 1'b0);
    chk("async reset mem_a", mem_a, 32'h0);
    chk("async reset mem_dout", mem_dout, 8'h0);
    chk("async reset if_inst", if_inst, 32'h0);
    chk("async reset ls_rdata", ls_rdata, 32'h0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post reset idle addr %0d", k), mem_a, 32'h0);
      chk($sformatf("post reset no finish %0d", k), if_finish | ls_finish, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between the instruction fetcher and the load/store buffer (LSB). It latches one pulse-style request per client, serialises word and sub-word accesses into byte beats, and returns assembled data with a one-cycle finish pulse. It sits between the issue/execute front end and the external memory bus, and is the only driver of `mem_a`, `mem_dout` and `mem_wr`.

## Interface
- `ADDR_W`, default 32: address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rdy` in 1: global enable; low freezes all state.
- `if_start` in 1: fetch request pulse.
- `if_addr` in ADDR_W: fetch address.
- `if_stop` in 1: abort fetch (misbranch).
- `if_finish` out 1: one-cycle pulse, `if_inst` valid.
- `if_inst` out 32: fetched instruction, little-endian.
- `ls_start` in 1: LSB request pulse.
- `ls_wr` in 1: 1 = store, 0 = load.
- `ls_size` in 3: byte count, 1, 2 or 4.
- `ls_addr` in ADDR_W: access address.
- `ls_wdata` in 32: store data; low bytes first.
- `ls_rollback` in 1: abort load (not store).
- `ls_finish` out 1: one-cycle pulse.
- `ls_rdata` out 32: load data, zero-extended; the LSB applies sign extension.
- `io_buffer_full` in 1: UART buffer full.
- `mem_din` in 8: RAM read byte, valid one cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out ADDR_W: RAM address.
- `mem_wr` out 1: 1 = write.

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR.
- Pending latches: `if_start` / `ls_start` set `if_pend` / `ls_pend` and capture the address, size and data.
  - A request arriving while busy is held until the block returns to IDLE.
  - A second start while a request is pending overwrites it.
- Arbitration in IDLE:
  - `ls_pend` wins over `if_pend`, because the LSB serves older instructions.
  - IF is served next, so it waits at most one LSB access.
- Beat counter `cnt` (3 bits) runs 0..size-1. `mem_a = base + cnt`.
- Read data assembly: byte k from `mem_din` goes into `data[8k+7:8k]`. Unfetched bytes are 0.
- Write data: `mem_dout = wdata[8·cnt+7:8·cnt]`, with `mem_wr = 1`.
- `if_stop`:
  - Clears `if_pend`.
  - If in IF_RD, returns to IDLE next edge and suppresses `if_finish`.
  - Wins over an `if_start` sampled on the same edge.
- `ls_rollback`:
  - Clears `ls_pend` when the pending request is a load.
  - In LS_RD, aborts the access and suppresses `ls_finish`.
  - Never affects stores, pending or in flight; stores are committed.
- `rdy` low: no register changes and `mem_wr` is forced to 0 combinationally. Because RAM also stalls, `mem_din` alignment is preserved.
- Reset values: state IDLE, both pending flags 0, `mem_a` 0, `mem_dout` 0, `mem_wr` 0, `if_finish`/`ls_finish` 0, `if_inst`/`ls_rdata` 0, `cnt` 0.

## Timing
- Take the request start sampled at edge N, with the block in IDLE and no competitor.
- Read of S bytes:
  - `mem_a` = addr+k is visible after edge N+1+k, for k = 0..S-1.
  - Byte k is sampled at edge N+2+k.
  - The finish pulse and data are visible after edge N+S+1, for one cycle.
  - Word fetch: 5 cycles from start to finish.
- Write of S bytes:
  - `mem_wr=1`, `mem_a`, `mem_dout` are visible after edges N+1..N+S.
  - `mem_wr` returns to 0 and `ls_finish` pulses after edge N+S+1.
- Turnaround: after a finish, a request that was already pending starts its first beat on the edge after the finish. There are no idle beats between back-to-back accesses.
- `mem_a` holds its last value when idle. `mem_wr` is 0 whenever the state is not LS_WR.

## Configuration
- `IO_STALL_EN` defined:
  - A store beat to I/O space (`addr[17:16] == 2'b11`) while `io_buffer_full` = 1 is not issued.
  - During the stall, `mem_wr` = 0 and `cnt` holds. The beat issues on the first cycle with `io_buffer_full` = 0.
  - Finish latency grows by the stall cycles.
- `IO_STALL_EN` undefined: `io_buffer_full` is ignored and stores follow the fixed timing above.

## Test plan
- Word fetch: `if_start`, `if_addr=0x100`, RAM bytes 13,05,00,00 → `mem_a` 0x100..0x103, `if_finish` 5 cycles later with `if_inst=0x00000513`.
- Simultaneous requests:
  - Stimulus: `if_start` at `0x0` together with a `ls_start` load, size 2, at `0x200`.
  - Response: LS served first, `ls_rdata=0x0000xxyy` after 3 cycles; IF beats begin the next cycle, with `if_finish` 5 cycles after that.
- Abort fetch: `if_stop` in the third IF beat → no `if_finish`, IDLE next cycle. A pending store then issues with `mem_wr=1` for 4 beats.
- Rollback boundaries:
  - `ls_rollback` during a size-4 load: no `ls_finish`.
  - `ls_rollback` during a size-1 store to `0x30000`: the write completes and `ls_finish` pulses.
- `IO_STALL_EN`, `io_buffer_full=1` for 3 cycles during a store to `0x30000`: `mem_wr` stays 0 for 3 cycles, then the byte is written and `ls_finish` arrives 3 cycles late. Without the macro, there is no stall.
- Reset and freeze:
  - `rst` pulse mid-LS_WR: `mem_wr` drops immediately (async), all outputs 0, pending cleared.
  - `rdy=0` for 2 cycles mid-fetch: the fetched word is still correct, with `if_finish` 2 cycles later.
